// File: rtl/pll_ctrl_pkg.sv
// Shared types and default constants for the ring-PLL control sequencer.
package pll_ctrl_pkg;

   localparam int unsigned       PllRatioW            = 8;
   localparam int unsigned       PllFracW             = 24;
   localparam logic [PllRatioW-1:0] PllDefaultRatio   = 8'd20;
   localparam int unsigned       PllLdoSettleCycles   = 256;
   localparam int unsigned       PllLockTimeoutCycles = 4096;
   localparam int unsigned       PllLockStableCycles  = 16;
   localparam int unsigned       PllSwitchCycles      = 4;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_LDO_UP,
      ST_WAIT_LOCK,
      ST_LOCKED,
      ST_DESEL,
      ST_RESTART,
      ST_ERROR
   } pll_ctrl_state_e;

   typedef struct packed {
      logic                 enable;
      logic [PllRatioW-1:0] ratio;
      logic [PllFracW-1:0]  fraction;
      logic                 ssc_en;
   } pll_cfg_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk_i domain.
module prim_flop_2sync #(
   parameter int unsigned      Width      = 1,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_reg <= ResetValue;
         q_o      <= ResetValue;
      end else begin
         meta_reg <= d_i;
         q_o      <= meta_reg;
      end
   end

endmodule

// File: rtl/pll_ctrl.sv
// Power-up, lock, clock handoff, reconfiguration and power-down sequencer for the ring PLL.
module pll_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int unsigned       RatioW            = PllRatioW,
   parameter int unsigned       FracW             = PllFracW,
   parameter logic [RatioW-1:0] DefaultRatio      = PllDefaultRatio,
   parameter int unsigned       LdoSettleCycles   = PllLdoSettleCycles,
   parameter int unsigned       LockTimeoutCycles = PllLockTimeoutCycles,
   parameter int unsigned       LockStableCycles  = PllLockStableCycles,
   parameter int unsigned       SwitchCycles      = PllSwitchCycles
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic              cfg_enable_i,
   input  logic [RatioW-1:0] cfg_ratio_i,
   input  logic [FracW-1:0]  cfg_fraction_i,
   input  logic              cfg_ssc_en_i,
   input  logic              pll_lock_i,
   output logic              ldo_enable_o,
   output logic              pllen_o,
   output logic [RatioW-1:0] ratio_o,
   output logic [FracW-1:0]  fraction_o,
   output logic              ssc_en_o,
   output logic              bypass_o,
   output logic              clk_sel_o,
   output logic              locked_o,
   output logic              busy_o,
   output logic              err_timeout_o,
   output logic              err_lock_lost_o
);

   localparam int unsigned       CntW        = $clog2(max3(LdoSettleCycles, LockTimeoutCycles,
                                                           SwitchCycles) + 1);
   localparam logic [CntW-1:0]   LdoLast     = CntW'(LdoSettleCycles - 1);
   localparam logic [CntW-1:0]   TimeoutLast = CntW'(LockTimeoutCycles - 1);
   localparam logic [CntW-1:0]   SwitchLast  = CntW'(SwitchCycles - 1);
   localparam int unsigned       StabW       = $clog2(LockStableCycles + 1);
   localparam logic [StabW-1:0]  StabTarget  = StabW'(LockStableCycles);

   pll_ctrl_state_e  state_reg;
   pll_cfg_t         cfg_reg;
   logic [CntW-1:0]  cnt_reg;
   logic [CntW-1:0]  cnt_inc;
   logic [StabW-1:0] stab_reg;
   logic [StabW-1:0] stab_next;
   logic             lock_s;
   logic             accept;

   prim_flop_2sync #(
      .Width      (1),
      .ResetValue (1'b0)
   ) u_lock_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (pll_lock_i),
      .q_o    (lock_s)
   );

   assign cfg_ready_o = (state_reg == ST_OFF) || (state_reg == ST_LOCKED) ||
                        (state_reg == ST_ERROR);
   assign accept      = cfg_valid_i && cfg_ready_o;
   assign cnt_inc     = (cnt_reg == {CntW{1'b1}}) ? cnt_reg : cnt_reg + CntW'(1);

   // Run length of consecutive synchronized lock samples; saturates at the target.
   always_comb begin
      stab_next = '0;
      if (lock_s) begin
         stab_next = (stab_reg == StabTarget) ? stab_reg : stab_reg + StabW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg       <= ST_OFF;
         cfg_reg         <= '{enable: 1'b0, ratio: DefaultRatio, fraction: '0, ssc_en: 1'b0};
         cnt_reg         <= '0;
         stab_reg        <= '0;
         ldo_enable_o    <= 1'b0;
         pllen_o         <= 1'b0;
         ratio_o         <= DefaultRatio;
         fraction_o      <= '0;
         ssc_en_o        <= 1'b0;
         bypass_o        <= 1'b1;
         clk_sel_o       <= 1'b0;
         locked_o        <= 1'b0;
         busy_o          <= 1'b0;
         err_timeout_o   <= 1'b0;
         err_lock_lost_o <= 1'b0;
      end else begin
         cnt_reg  <= cnt_inc;
         stab_reg <= stab_next;

         // Divider settings only reach the PLL while it is disabled.
         if (accept) begin
            cfg_reg.enable <= cfg_enable_i;
            if (cfg_enable_i) begin
               cfg_reg.ratio    <= cfg_ratio_i;
               cfg_reg.fraction <= cfg_fraction_i;
               cfg_reg.ssc_en   <= cfg_ssc_en_i;
               if (!pllen_o) begin
                  ratio_o    <= cfg_ratio_i;
                  fraction_o <= cfg_fraction_i;
                  ssc_en_o   <= cfg_ssc_en_i;
               end
            end
         end

         case (state_reg)
            ST_OFF, ST_ERROR: begin
               if (accept && cfg_enable_i) begin
                  state_reg       <= ST_LDO_UP;
                  cnt_reg         <= '0;
                  ldo_enable_o    <= 1'b1;
                  busy_o          <= 1'b1;
                  err_timeout_o   <= 1'b0;
                  err_lock_lost_o <= 1'b0;
               end else if (accept && (state_reg == ST_ERROR)) begin
                  state_reg       <= ST_OFF;
                  err_timeout_o   <= 1'b0;
                  err_lock_lost_o <= 1'b0;
               end
            end
            ST_LDO_UP: begin
               if (cnt_reg == LdoLast) begin
                  state_reg <= ST_WAIT_LOCK;
                  cnt_reg   <= '0;
                  stab_reg  <= '0;
                  pllen_o   <= 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (stab_next == StabTarget) begin
                  state_reg <= ST_LOCKED;
                  cnt_reg   <= '0;
                  clk_sel_o <= 1'b1;
                  bypass_o  <= 1'b0;
                  locked_o  <= 1'b1;
                  busy_o    <= 1'b0;
               end else if (cnt_reg == TimeoutLast) begin
                  state_reg     <= ST_ERROR;
                  cnt_reg       <= '0;
                  pllen_o       <= 1'b0;
                  ldo_enable_o  <= 1'b0;
                  busy_o        <= 1'b0;
                  err_timeout_o <= 1'b1;
               end
            end
            ST_LOCKED: begin
               // A request takes priority over a simultaneous lock drop.
               if (accept || !lock_s) begin
                  state_reg <= accept ? ST_DESEL : ST_WAIT_LOCK;
                  cnt_reg   <= '0;
                  stab_reg  <= '0;
                  clk_sel_o <= 1'b0;
                  bypass_o  <= 1'b1;
                  locked_o  <= 1'b0;
                  busy_o    <= 1'b1;
                  if (!accept) begin
                     err_lock_lost_o <= 1'b1;
                  end
               end
            end
            ST_DESEL: begin
               if (cnt_reg == SwitchLast) begin
                  cnt_reg <= '0;
                  pllen_o <= 1'b0;
                  if (cfg_reg.enable) begin
                     state_reg  <= ST_RESTART;
                     ratio_o    <= cfg_reg.ratio;
                     fraction_o <= cfg_reg.fraction;
                     ssc_en_o   <= cfg_reg.ssc_en;
                  end else begin
                     state_reg    <= ST_OFF;
                     ldo_enable_o <= 1'b0;
                     busy_o       <= 1'b0;
                  end
               end
            end
            ST_RESTART: begin
               state_reg <= ST_WAIT_LOCK;
               cnt_reg   <= '0;
               stab_reg  <= '0;
               pllen_o   <= 1'b1;
            end
            default: begin
               state_reg <= ST_OFF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_ctrl.sv
// Directed bench for pll_ctrl: deadline-based reference model checked every cycle, plus pinned literals.
module tb_pll_ctrl;

   localparam int LDO     = 8;
   localparam int TIMEOUT = 64;
   localparam int STABLE  = 4;
   localparam int SWITCH  = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        cfg_valid_i = 1'b0;
   logic        cfg_ready_o;
   logic        cfg_enable_i = 1'b0;
   logic [7:0]  cfg_ratio_i = '0;
   logic [23:0] cfg_fraction_i = '0;
   logic        cfg_ssc_en_i = 1'b0;
   logic        pll_lock_i = 1'b0;
   logic        ldo_enable_o, pllen_o, ssc_en_o, bypass_o, clk_sel_o, locked_o, busy_o;
   logic        err_timeout_o, err_lock_lost_o;
   logic [7:0]  ratio_o;
   logic [23:0] fraction_o;

   pll_ctrl #(
      .LdoSettleCycles   (LDO),
      .LockTimeoutCycles (TIMEOUT),
      .LockStableCycles  (STABLE),
      .SwitchCycles      (SWITCH)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .cfg_valid_i     (cfg_valid_i),
      .cfg_ready_o     (cfg_ready_o),
      .cfg_enable_i    (cfg_enable_i),
      .cfg_ratio_i     (cfg_ratio_i),
      .cfg_fraction_i  (cfg_fraction_i),
      .cfg_ssc_en_i    (cfg_ssc_en_i),
      .pll_lock_i      (pll_lock_i),
      .ldo_enable_o    (ldo_enable_o),
      .pllen_o         (pllen_o),
      .ratio_o         (ratio_o),
      .fraction_o      (fraction_o),
      .ssc_en_o        (ssc_en_o),
      .bypass_o        (bypass_o),
      .clk_sel_o       (clk_sel_o),
      .locked_o        (locked_o),
      .busy_o          (busy_o),
      .err_timeout_o   (err_timeout_o),
      .err_lock_lost_o (err_lock_lost_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_OFF, M_LDO, M_ACQ, M_RUN, M_SWITCH, M_REPROG, M_FAULT} mphase_e;

   mphase_e     m_phase;
   int          deadline, acq_start;
   bit          e_err_to, e_err_ll;
   bit          want_en;
   logic [7:0]  want_ratio, m_ratio;
   logic [23:0] want_frac, m_frac;
   bit          want_ssc, m_ssc;
   bit          lock_rec [0:1023];

   function automatic bit m_ready(input mphase_e p);
      return p inside {M_OFF, M_RUN, M_FAULT};
   endfunction

   function automatic bit m_pllen(input mphase_e p);
      return p inside {M_ACQ, M_RUN, M_SWITCH};
   endfunction

   // synchronized lock value seen during cycle x
   function automatic bit ls(input int x);
      if (x < 2 || x - 2 > 1023) return 1'b0;
      return lock_rec[x-2];
   endfunction

   function automatic bit window_ok(input int c);
      if (c - STABLE + 1 < acq_start) return 1'b0;
      for (int k = 0; k < STABLE; k++) if (!ls(c - k)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_phase = M_OFF; deadline = 0; acq_start = 0;
      e_err_to = 0; e_err_ll = 0;
      want_en = 0; want_ratio = 8'd20; want_frac = '0; want_ssc = 0;
      m_ratio = 8'd20; m_frac = '0; m_ssc = 0;
   endtask

   task automatic start_acq(input int c);
      m_phase = M_ACQ; acq_start = c + 1; deadline = c + TIMEOUT;
   endtask

   task automatic model_edge(input int c);
      bit acc;
      if (c <= 1023) lock_rec[c] = pll_lock_i;
      acc = cfg_valid_i && m_ready(m_phase);
      if (acc) begin
         want_en = cfg_enable_i;
         if (cfg_enable_i) begin
            want_ratio = cfg_ratio_i; want_frac = cfg_fraction_i; want_ssc = cfg_ssc_en_i;
         end
      end
      case (m_phase)
         M_OFF: if (acc && cfg_enable_i) begin
            e_err_to = 0; e_err_ll = 0; m_phase = M_LDO; deadline = c + LDO;
         end
         M_FAULT: if (acc) begin
            e_err_to = 0; e_err_ll = 0;
            if (cfg_enable_i) begin m_phase = M_LDO; deadline = c + LDO; end
            else m_phase = M_OFF;
         end
         M_LDO: if (c == deadline) start_acq(c);
         M_ACQ: begin
            if (window_ok(c)) m_phase = M_RUN;
            else if (c == deadline) begin m_phase = M_FAULT; e_err_to = 1; end
         end
         M_RUN: begin
            if (acc) begin m_phase = M_SWITCH; deadline = c + SWITCH; end
            else if (!ls(c)) begin e_err_ll = 1; start_acq(c); end
         end
         M_SWITCH: if (c == deadline) m_phase = want_en ? M_REPROG : M_OFF;
         M_REPROG: start_acq(c);
         default: m_phase = M_OFF;
      endcase
      if (!m_pllen(m_phase)) begin
         m_ratio = want_ratio; m_frac = want_frac; m_ssc = want_ssc;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk_i or negedge rst_ni);
         if (!rst_ni) begin
            model_reset();
            if (clk_i && cyc <= 1023) lock_rec[cyc] = 1'b0;
         end else begin
            model_edge(cyc);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [7:0] prev_ratio;
   bit         have_prev = 0;

   initial begin
      forever begin
         @(negedge clk_i);
         chk("cfg_ready",     cfg_ready_o,     m_ready(m_phase));
         chk("ldo_enable",    ldo_enable_o,    !(m_phase inside {M_OFF, M_FAULT}));
         chk("pllen",         pllen_o,         m_pllen(m_phase));
         chk("ratio",         ratio_o,         m_ratio);
         chk("fraction",      fraction_o,      m_frac);
         chk("ssc_en",        ssc_en_o,        m_ssc);
         chk("bypass",        bypass_o,        m_phase != M_RUN);
         chk("clk_sel",       clk_sel_o,       m_phase == M_RUN);
         chk("locked",        locked_o,        m_phase == M_RUN);
         chk("busy",          busy_o,          m_phase inside {M_LDO, M_ACQ, M_SWITCH, M_REPROG});
         chk("err_timeout",   err_timeout_o,   e_err_to);
         chk("err_lock_lost", err_lock_lost_o, e_err_ll);
         if (have_prev && ratio_o !== prev_ratio) chk("ratio_change_pll_off", pllen_o, 1'b0);
         prev_ratio = ratio_o;
         have_prev  = 1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic go_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic req(input bit en, input logic [7:0] r, input logic [23:0] f, input bit s);
      $display("req cycle=%0d en=%0d ratio=%0d frac=%0h ssc=%0d ready=%0d", cyc, en, r, f, s,
               cfg_ready_o);
      cfg_valid_i = 1; cfg_enable_i = en; cfg_ratio_i = r; cfg_fraction_i = f; cfg_ssc_en_i = s;
      step();
      cfg_valid_i = 0; cfg_enable_i = 0; cfg_ratio_i = '0; cfg_fraction_i = '0; cfg_ssc_en_i = 0;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_bypass"}, bypass_o, 1);
      chk({tag, "_ratio"}, ratio_o, 20);
      chk({tag, "_ready"}, cfg_ready_o, 1);
      chk({tag, "_ldo"}, ldo_enable_o, 0);
      chk({tag, "_pllen"}, pllen_o, 0);
      chk({tag, "_clk_sel"}, clk_sel_o, 0);
      chk({tag, "_locked"}, locked_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_errs"}, {err_timeout_o, err_lock_lost_o}, 0);
      chk({tag, "_frac_ssc"}, {fraction_o, ssc_en_o}, 0);
      chk({tag, "_no_x"}, $isunknown({cfg_ready_o, ldo_enable_o, pllen_o, ratio_o, fraction_o,
          ssc_en_o, bypass_o, clk_sel_o, locked_o, busy_o, err_timeout_o, err_lock_lost_o}), 0);
   endtask

   int t, l, r, p, e, q;

   initial begin
      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk_reset_values("reset");
      rst_ni = 1'b1;
      step();

      // power-up with lock
      t = cyc;
      req(1, 8'd40, 24'h123456, 1);
      chk("pu_ldo_t1", ldo_enable_o, 1);
      chk("pu_ratio_t1", ratio_o, 40);
      chk("pu_pllen_t1", pllen_o, 0);
      go_to(t + 8);  chk("pu_pllen_t8", pllen_o, 0);
      go_to(t + 9);  chk("pu_pllen_t9", pllen_o, 1);
      go_to(t + 12); pll_lock_i = 1;
      go_to(t + 17); chk("pu_locked_t17", locked_o, 0);
      go_to(t + 18); chk("pu_locked_t18", {locked_o, clk_sel_o, bypass_o, busy_o}, 4'b1100);

      // single-cycle lock loss, auto-relock
      go_to(t + 25); l = cyc; pll_lock_i = 0; step(); pll_lock_i = 1;
      go_to(l + 2); chk("ll_clk_sel_l2", clk_sel_o, 1);
      go_to(l + 3); chk("ll_state_l3", {clk_sel_o, err_lock_lost_o, pllen_o, busy_o}, 4'b0111);
      go_to(l + 6); chk("ll_locked_l6", locked_o, 0);
      go_to(l + 7); chk("ll_locked_l7", locked_o, 1);

      // reconfigure to ratio 50
      go_to(l + 12); r = cyc;
      req(1, 8'd50, 24'h0ABCDE, 0);
      chk("rc_r1", {clk_sel_o, pllen_o}, 2'b01); chk("rc_ratio_r1", ratio_o, 40);
      go_to(r + 2); chk("rc_r2", {clk_sel_o, pllen_o}, 2'b01);
      go_to(r + 3); chk("rc_pllen_r3", pllen_o, 0); chk("rc_ratio_r3", ratio_o, 50);
      pll_lock_i = 0;
      go_to(r + 4); chk("rc_pllen_r4", pllen_o, 1);
      go_to(r + 6); pll_lock_i = 1;
      go_to(r + 11); chk("rc_locked_r11", locked_o, 0);
      go_to(r + 12); chk("rc_locked_r12", locked_o, 1);

      // power down
      go_to(r + 16); p = cyc;
      req(0, 8'd0, 24'h0, 0);
      go_to(p + 2); chk("pd_p2", {pllen_o, ldo_enable_o}, 2'b11);
      go_to(p + 3); chk("pd_p3", {pllen_o, ldo_enable_o, busy_o, cfg_ready_o}, 4'b0001);
      chk("pd_ratio_p3", ratio_o, 50);
      pll_lock_i = 0;

      // no lock, with a 3-cycle lock pulse that must not lock
      go_to(p + 6); t = cyc;
      req(1, 8'd60, 24'h000FFF, 1);
      go_to(t + 20); pll_lock_i = 1;
      go_to(t + 23); pll_lock_i = 0;
      go_to(t + 30); chk("nl_locked_t30", {locked_o, busy_o}, 2'b01);
      go_to(t + 72); chk("nl_t72", {err_timeout_o, pllen_o}, 2'b01);
      go_to(t + 73); chk("nl_t73", {err_timeout_o, pllen_o, ldo_enable_o, busy_o, cfg_ready_o},
                         5'b10001);

      // recover from error
      go_to(t + 76); e = cyc;
      req(1, 8'd60, 24'h000FFF, 1);
      chk("er_e1", {err_timeout_o, ldo_enable_o, busy_o}, 3'b011);
      go_to(e + 12); pll_lock_i = 1;
      go_to(e + 18); chk("er_locked_e18", locked_o, 1);

      // request in the same cycle the synchronized lock falls
      go_to(e + 22); q = cyc; pll_lock_i = 0;
      go_to(q + 2); req(1, 8'd70, 24'h00AA55, 0);
      chk("race_q3", {err_lock_lost_o, clk_sel_o, busy_o}, 3'b001);
      go_to(q + 6); chk("race_pllen_q6", pllen_o, 1); chk("race_ratio_q6", ratio_o, 70);

      // asynchronous reset while waiting for lock
      go_to(q + 10);
      rst_ni = 1'b0;
      #1;
      chk_reset_values("midrst");
      repeat (3) step();
      rst_ni = 1'b1;
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
